// File: rtl/mel_frame_sched.sv
// rtl/mel_frame_sched.sv - frame sequencer between the sample FIFO and MEL_SPEC
// Ring-buffers overlapping frames and streams each one, zero-padded to N_FFT.
module mel_frame_sched #(
  parameter int WIDTH     = 16,
  parameter int N_FRAMES  = 101,
  parameter int N_FFT     = 512,
  parameter int WIN_LEN   = 480,
  parameter int HOP_LEN   = 160,
  parameter int BUF_DEPTH = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        fifo_rd_en,
  input  logic [WIDTH-1:0]            fifo_rd_data,
  input  logic                        fifo_empty,
  output logic                        spec_start,
  output logic                        spec_valid,
  output logic                        spec_win_en,
  output logic [WIDTH-1:0]            spec_re,
  output logic [WIDTH-1:0]            spec_im,
  input  logic                        spec_mel_avail,
  output logic [$clog2(N_FRAMES)-1:0] frame_idx,
  output logic                        err_mel
);

  localparam int TOTAL = (N_FRAMES - 1) * HOP_LEN + WIN_LEN;
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int OW    = AW + 1;
  localparam int KW    = $clog2(N_FFT + 1);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int FW    = $clog2(N_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_WAIT_MEL,
    ST_DONE
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]  base;
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rd_addr;
  logic [OW-1:0]  occ;
  logic [OW-1:0]  written;
  logic [CW-1:0]  fetched;
  logic [KW-1:0]  k;
  logic           wr_pend;
  logic           stream_last;

  // occ counts a pop as soon as it is issued; its data lands one cycle later
  assign written     = occ - {{AW{1'b0}}, wr_pend};
  assign rd_addr     = base + AW'(k);
  assign stream_last = (state == ST_STREAM) && (k == KW'(N_FFT - 1));
  assign spec_im     = '0;

  assign fifo_rd_en = (state != ST_IDLE) && !fifo_empty &&
                      (occ < OW'(BUF_DEPTH)) && (fetched < CW'(TOTAL));

  always_ff @(posedge clk) begin
    if (wr_pend) begin
      mem[wptr] <= fifo_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      spec_start  <= 1'b0;
      spec_valid  <= 1'b0;
      spec_win_en <= 1'b0;
      spec_re     <= '0;
      frame_idx   <= '0;
      err_mel     <= 1'b0;
      base        <= '0;
      wptr        <= '0;
      occ         <= '0;
      fetched     <= '0;
      k           <= '0;
      wr_pend     <= 1'b0;
    end else begin
      spec_start  <= 1'b0;
      spec_valid  <= 1'b0;
      spec_win_en <= 1'b0;
      spec_re     <= '0;
      done        <= 1'b0;

      wr_pend <= fifo_rd_en;
      if (wr_pend) begin
        wptr <= wptr + 1'b1;
      end
      if (fifo_rd_en) begin
        fetched <= fetched + 1'b1;
      end
      // a pop and the end-of-frame hop may land together: both apply
      occ <= occ + OW'(fifo_rd_en) - (stream_last ? OW'(HOP_LEN) : OW'(0));

      if (spec_mel_avail && (state != ST_WAIT_MEL)) begin
        err_mel <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FILL;
            busy      <= 1'b1;
            fetched   <= '0;
            base      <= '0;
            wptr      <= '0;
            occ       <= '0;
            wr_pend   <= 1'b0;
            frame_idx <= '0;
            err_mel   <= 1'b0;
          end
        end
        ST_FILL: begin
          if (written >= OW'(WIN_LEN)) begin
            state      <= ST_STREAM;
            k          <= '0;
            spec_start <= 1'b1;
          end
        end
        ST_STREAM: begin
          spec_valid <= 1'b1;
          if (k < KW'(WIN_LEN)) begin
            spec_re     <= mem[rd_addr];
            spec_win_en <= 1'b1;
          end
          k <= k + 1'b1;
          if (stream_last) begin
            base  <= base + AW'(HOP_LEN);
            state <= ST_WAIT_MEL;
          end
        end
        ST_WAIT_MEL: begin
          if (spec_mel_avail) begin
            if (frame_idx == FW'(N_FRAMES - 1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              frame_idx <= frame_idx + 1'b1;
              state     <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mel_frame_sched.md
Name: mel_frame_sched

Overview:
- Sequences the MEL_SPEC datapath for one utterance.
- Pulls 16-bit audio samples from the command-side sample FIFO into an internal ring buffer of overlapping frames.
- Streams each frame (WIN_LEN windowed samples, then zero-padding to N_FFT) into MEL_SPEC, then waits for mel_avail before issuing the next frame.
- Sits between the ICB sample FIFO read port and the MEL_SPEC input ports inside the ICB MSP wrapper.

Parameters:
- WIDTH, 16, sample width.
- N_FRAMES, 101, frames per utterance.
- N_FFT, 512, samples streamed per frame; must be >= WIN_LEN.
- WIN_LEN, 480, windowed samples per frame.
- HOP_LEN, 160, frame advance in samples; must be <= WIN_LEN.
- BUF_DEPTH, 512, ring buffer depth; power of 2, >= WIN_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an utterance.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last frame's mel_avail.
- fifo_rd_en  out  1  sample FIFO pop.
- fifo_rd_data  in  WIDTH  FIFO data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty.
- spec_start  out  1  one-cycle pulse in the cycle before the first spec_valid of each frame.
- spec_valid  out  1  sample strobe to MEL_SPEC.
- spec_win_en  out  1  window-coefficient LUT enable; high only for indices k < WIN_LEN.
- spec_re  out  WIDTH  real sample.
- spec_im  out  WIDTH  imaginary sample; always 0.
- spec_mel_avail  in  1  MEL_SPEC frame-complete pulse.
- frame_idx  out  $clog2(N_FRAMES)  index of the frame in progress.
- err_mel  out  1  sticky; spec_mel_avail seen outside WAIT_MEL. Cleared by accepted start.

Behaviour:
- Reset: all outputs 0; state IDLE; all pointers and counters 0. Asynchronous reset mid-utterance aborts immediately. A start is required afterwards; the FIFO is not flushed.
- Utterance length: TOTAL = (N_FRAMES-1)*HOP_LEN + WIN_LEN samples; 16480 at defaults.
- Counters:
  - fetched: samples popped so far, 0..TOTAL.
  - base: frame start address, modulo BUF_DEPTH.
  - wptr: write address, modulo BUF_DEPTH.
  - occ: samples in the buffer plus pops in flight, measured from base; width $clog2(BUF_DEPTH)+1.
- Fetch path:
  - Runs in every state except IDLE.
  - fifo_rd_en = !fifo_empty && occ < BUF_DEPTH && fetched < TOTAL.
  - occ increments on the fifo_rd_en cycle. The buffer write buf[wptr] <= fifo_rd_data happens the following cycle, then wptr increments.
  - Writes land only at addresses in [base+occ, base+BUF_DEPTH), so the active frame is never overwritten.
- States:
  - IDLE: start -> FILL; clears fetched, base, wptr, occ, frame_idx and err_mel; busy=1. Start while busy is ignored.
  - FILL: when the number of written samples from base reaches >= WIN_LEN -> STREAM. Pops in flight do not count toward this threshold.
  - STREAM:
    - Counter k runs 0..N_FFT-1, one per cycle, no stalls.
    - The buffer read has 1-cycle latency. spec_valid, spec_re and spec_win_en are registered and aligned with the read data, so each appears 1 cycle after its k.
    - Output for k < WIN_LEN: spec_re = buf[base+k], spec_win_en=1.
    - Output for k >= WIN_LEN: spec_re = 0, spec_win_en=0.
    - spec_start is asserted in the cycle with k=0.
    - After k = N_FFT-1: base += HOP_LEN (mod BUF_DEPTH), occ -= HOP_LEN, then -> WAIT_MEL.
    - If a fetch increment and the HOP_LEN decrement hit occ in the same cycle, both apply: net +1-HOP_LEN.
  - WAIT_MEL: on spec_mel_avail:
    - if frame_idx == N_FRAMES-1 -> DONE;
    - otherwise frame_idx++, then -> FILL. FILL passes straight through to STREAM if data is already sufficient; FILL costs 1 cycle minimum.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- spec_mel_avail in IDLE, FILL, STREAM or DONE sets err_mel and is otherwise ignored.
- Latency:
  - From start, with a non-empty FIFO supplying 1 sample/cycle, the first spec_start comes WIN_LEN+3 cycles later.
  - Per-frame stream length is exactly N_FFT spec_valid cycles, contiguous.
- Simultaneous start and spec_mel_avail in IDLE: start is accepted, and err_mel is left cleared.

Test Plan:
- Defaults; FIFO preloaded with ramp 0..16479; start, with spec_mel_avail returned 20 cycles after each frame's last spec_valid -> exactly 101 frames.
  - Frame f: spec_re = 160f .. 160f+479 with spec_win_en=1, then 32 zeros with spec_win_en=0.
  - spec_im always 0; done pulses once; 16480 pops total; fifo_rd_en never asserted after that.
- FIFO starved: 1 sample every 4 cycles -> spec_valid bursts are still 512 contiguous cycles, no repeated or skipped sample; frame 1 starts only after sample 639 is written.
- spec_mel_avail pulsed during STREAM of frame 0 -> err_mel=1, frame_idx stays 0. The real spec_mel_avail in WAIT_MEL then advances to frame 1. A subsequent start clears err_mel.
- start pulsed again mid frame 5 -> ignored; the sequence completes with 101 frames.
- rst_n low during STREAM of frame 3 -> all outputs 0 asynchronously; after release, start restarts at frame_idx 0 with base 0.
- BUF_DEPTH=512, fast FIFO -> occ never exceeds 512. Ring wrap-around at base 480→128 (frame 3) gives correct samples 480..959.
